fetch_stage: RTL and testbench

- IF stage of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the byte address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall (hazard unit) and redirect/flush (branch/jump resolution), and keeps a retired-fetch counter.

---
 rtl/fetch_stage.sv | 52 +++++
 tb/tb_fetch_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ==== fetch_stage : RISC-V IF stage (PC, imem address, IF/ID register) ====
// ==== rev 1.0                                                          ====
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign imem_addr  = r_pc;

  // Redirect outranks stall: a taken branch must squash even a held fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      if_id_inst     <= NOP_INST;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'd0;
    end else if (redirect) begin
      r_pc        <= {redirect_pc[31:2], 2'b00};
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc           <= w_pc_plus4;
      if_id_inst     <= imem_inst;
      if_id_pc       <= r_pc;
      if_id_pc_plus4 <= w_pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ==== tb_fetch_stage : directed self-checking bench for fetch_stage ====
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_inst, fetch_count;
  logic        if_id_valid;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory word i holds 32'h1000_0000 + i.
  assign imem_inst = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] inst, input logic valid, input logic [31:0] cnt);
    chk({tag, ".pc"},    if_id_pc,       pc);
    chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
    chk({tag, ".inst"},  if_id_inst,     inst);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    chk({tag, ".count"}, fetch_count,    cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step();
    chk("rst.addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'd0);

    // Free-running fetch of four words.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("run.addr", imem_addr, 32'(4 * i));
      step();
      chk_ifid("run", 32'(4 * i), 32'(4 * i + 4), 32'h1000_0000 + 32'(i), 1'b1, 32'(i + 1));
    end
    chk("run.addr_end", imem_addr, 32'h10);

    // Re-reset, advance twice to reach pc=8.
    rst_n = 1'b0; step();
    rst_n = 1'b1; step(); step();
    chk("pre_stall.addr", imem_addr, 32'h8);
    chk_ifid("pre_stall", 32'h4, 32'h8, 32'h1000_0001, 1'b1, 32'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", imem_addr, 32'h8);
      chk_ifid("stall", 32'h4, 32'h8, 32'h1000_0001, 1'b1, 32'd2);
    end
    stall = 1'b0; step();
    chk("release.addr", imem_addr, 32'hC);
    chk_ifid("release", 32'h8, 32'hC, 32'h1000_0002, 1'b1, 32'd3);

    // Redirect wins over stall; misaligned target bits dropped.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0043; step();
    chk("redir.addr", imem_addr, 32'h40);
    chk_ifid("redir", 32'h8, 32'hC, 32'h0000_0013, 1'b0, 32'd3);
    stall = 1'b0; redirect = 1'b0; step();
    chk("redir_next.addr", imem_addr, 32'h44);
    chk_ifid("redir_next", 32'h40, 32'h44, 32'h1000_0010, 1'b1, 32'd4);

    // PC wrap at top of address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
    redirect = 1'b0;
    chk("wrap_redir.addr", imem_addr, 32'hFFFF_FFFC);
    chk_ifid("wrap_redir", 32'h40, 32'h44, 32'h0000_0013, 1'b0, 32'd4);
    step();
    chk("wrap1.addr", imem_addr, 32'h0);
    chk_ifid("wrap1", 32'hFFFF_FFFC, 32'h0, 32'h4FFF_FFFF, 1'b1, 32'd5);
    step();
    chk("wrap2.addr", imem_addr, 32'h4);
    chk_ifid("wrap2", 32'h0, 32'h4, 32'h1000_0000, 1'b1, 32'd6);

    // Reset in the middle of a stall at pc=0x20.
    redirect = 1'b1; redirect_pc = 32'h20; step();
    redirect = 1'b0; stall = 1'b1; step();
    chk("pre_rst.addr", imem_addr, 32'h20);
    rst_n = 1'b0; step();
    chk("mid_rst.addr", imem_addr, 32'h0);
    chk_ifid("mid_rst", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'd0);
    rst_n = 1'b1; stall = 1'b0; step();
    chk("post_rst.addr", imem_addr, 32'h4);
    chk_ifid("post_rst", 32'h0, 32'h4, 32'h1000_0000, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
